vsim_source_arbiter: RTL and testbench

Round-robin, message-atomic arbiter that shares one simulation message source (the DPI beat sink consuming `beat`/`last`) among `nports` requesters. Once granted, a requester keeps the source until it sends a beat with `last`=1, so messages are never interleaved. Beats pass through one output register stage toward the sink. It also reports the winning port, counts completed messages and flags over-length messages.

---
 rtl/vsim_source_arbiter_pkg.sv | 16 +
 rtl/vsim_source_arbiter_rr_pick.sv | 33 +++
 rtl/vsim_source_arbiter.sv | 108 ++++++++++
 tb/tb_vsim_source_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vsim_source_arbiter_pkg.sv
// Shared types and helpers for the simulation message-source arbiter.
package vsim_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int MSG_COUNT_W = 32;

  // Port-id width; never narrower than one bit.
  function automatic int port_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vsim_source_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after ptr, wrapping modulo nports.
// Purely combinational; no backpressure of its own.
module rr_pick
  import vsim_arb_pkg::*;
#(
  parameter  int nports = 4,
  localparam int PW     = port_w(nports)
) (
  input  logic [nports-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic              valid,
  output logic [PW-1:0]     idx
);

  // Scan farthest candidate first so the nearest one after ptr wins last.
  always_comb begin
    int          c;
    logic [PW-1:0] ci;
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    ci    = '0;
    for (int k = nports; k >= 1; k--) begin
      c  = (int'(ptr) + k) % nports;
      ci = PW'(c);
      if (req[ci]) begin
        valid = 1'b1;
        idx   = ci;
      end
    end
  end

endmodule

// File: rtl/vsim_source_arbiter.sv
// Message-atomic round-robin arbiter feeding one beat sink through an output register.
// Latency 1 cycle grant->out_RDY_beat; a stalled sink withholds every req_EN_beat.
module vsim_source_arbiter
  import vsim_arb_pkg::*;
#(
  parameter  int width    = 32,
  parameter  int nports   = 4,
  parameter  int maxbeats = 256,
  localparam int PW       = port_w(nports),
  localparam int BW       = $clog2(maxbeats + 1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [nports-1:0]        req_RDY_beat,
  input  logic [nports*width-1:0]  req_beat,
  input  logic [nports-1:0]        req_last,
  output logic [nports-1:0]        req_EN_beat,
  output logic                     out_RDY_beat,
  output logic [width-1:0]         out_beat,
  output logic                     out_last,
  output logic [PW-1:0]            out_port,
  input  logic                     out_EN_beat,
  output logic [MSG_COUNT_W-1:0]   msg_count,
  output logic                     err_overlength
);

  arb_state_t      state;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   ptr;
  logic [BW-1:0]   bcnt;

  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   gnt;
  logic            gnt_vld;
  logic            can_take;
  logic            xfer;
  logic [width-1:0] sel_beat;
  logic            sel_last;
  logic            sel_rdy;

  rr_pick #(.nports(nports)) u_pick (
    .req   (req_RDY_beat),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    can_take    = !out_RDY_beat || out_EN_beat;
    gnt         = (state == LOCKED) ? owner : pick_idx;
    gnt_vld     = (state == LOCKED) ? 1'b1  : pick_vld;
    sel_beat    = '0;
    sel_last    = 1'b0;
    sel_rdy     = 1'b0;
    req_EN_beat = '0;
    for (int i = 0; i < nports; i++) begin
      if (gnt == PW'(i)) begin
        sel_beat = req_beat[i*width +: width];
        sel_last = req_last[i];
        sel_rdy  = req_RDY_beat[i];
      end
    end
    // A locked owner that drops its request simply stalls everyone.
    xfer = !RST && gnt_vld && sel_rdy && can_take;
    for (int i = 0; i < nports; i++) begin
      req_EN_beat[i] = xfer && (gnt == PW'(i));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      owner          <= '0;
      ptr            <= PW'(nports - 1);
      bcnt           <= '0;
      out_RDY_beat   <= 1'b0;
      out_beat       <= '0;
      out_last       <= 1'b0;
      out_port       <= '0;
      msg_count      <= '0;
      err_overlength <= 1'b0;
    end else begin
      if (xfer) begin
        out_RDY_beat <= 1'b1;
        out_beat     <= sel_beat;
        out_last     <= sel_last;
        out_port     <= gnt;
        if (sel_last) begin
          state <= IDLE;
          ptr   <= gnt;
          bcnt  <= '0;
        end else begin
          state <= LOCKED;
          owner <= gnt;
          if (bcnt != BW'(maxbeats)) bcnt <= bcnt + BW'(1);
          if (bcnt == BW'(maxbeats - 1)) err_overlength <= 1'b1;
        end
      end else if (out_EN_beat) begin
        out_RDY_beat <= 1'b0;
      end
      if (out_RDY_beat && out_EN_beat && out_last) begin
        msg_count <= msg_count + MSG_COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vsim_source_arbiter.sv
// Directed and randomized checks of vsim_source_arbiter against a message-level reference model.
module tb_vsim_source_arbiter;

  localparam int W    = 32;
  localparam int N    = 4;
  localparam int MAXB = 4;
  localparam int PW   = 2;

  logic             CLK = 1'b0;
  logic             RST;
  logic [N-1:0]     req_RDY_beat;
  logic [N*W-1:0]   req_beat;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_EN_beat;
  logic             out_RDY_beat;
  logic [W-1:0]     out_beat;
  logic             out_last;
  logic [PW-1:0]    out_port;
  logic             out_EN_beat;
  logic [31:0]      msg_count;
  logic             err_overlength;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_locked;
  int          m_owner;
  int          m_ptr;
  int          m_bcnt;
  bit          m_err;
  bit          m_ov;
  logic [W-1:0] m_beat;
  bit          m_last;
  int          m_port;
  logic [31:0] m_msg;
  logic [N-1:0] en_seen;

  vsim_source_arbiter #(.width(W), .nports(N), .maxbeats(MAXB)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .req_RDY_beat   (req_RDY_beat),
    .req_beat       (req_beat),
    .req_last       (req_last),
    .req_EN_beat    (req_EN_beat),
    .out_RDY_beat   (out_RDY_beat),
    .out_beat       (out_beat),
    .out_last       (out_last),
    .out_port       (out_port),
    .out_EN_beat    (out_EN_beat),
    .msg_count      (msg_count),
    .err_overlength (err_overlength)
  );

  always #5 CLK = ~CLK;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = N - 1; m_bcnt = 0; m_err = 0;
    m_ov = 0; m_beat = '0; m_last = 0; m_port = 0; m_msg = '0;
  endtask

  function automatic int model_grant();
    if (m_locked) return req_RDY_beat[m_owner] ? m_owner : -1;
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (m_ptr + k) % N;
      if (req_RDY_beat[p]) return p;
    end
    return -1;
  endfunction

  // One clock: check outputs and grants against the model, then advance both.
  task automatic step(output int gx);
    int           g;
    bit           xfer;
    logic [N-1:0] e;
    logic [W-1:0] b;
    bit           l;
    bit           take_last;
    g    = model_grant();
    xfer = (RST == 1'b0) && (g >= 0) && (!m_ov || out_EN_beat);
    e    = '0;
    b    = '0;
    l    = 0;
    if (xfer) begin
      e[g] = 1'b1;
      b    = req_beat[g*W +: W];
      l    = req_last[g];
    end
    #1;
    en_seen = req_EN_beat;
    chk_eq("req_EN_beat", req_EN_beat, e);
    chk_eq("out_RDY_beat", out_RDY_beat, m_ov);
    chk_eq("out_beat", out_beat, m_beat);
    chk_eq("out_last", out_last, m_last);
    chk_eq("out_port", out_port, m_port);
    chk_eq("msg_count", msg_count, m_msg);
    chk_eq("err_overlength", err_overlength, m_err);
    take_last = m_ov && out_EN_beat && m_last;
    @(posedge CLK);
    if (RST) begin
      model_reset();
    end else begin
      if (take_last) m_msg++;
      if (xfer) begin
        m_ov = 1; m_beat = b; m_last = l; m_port = g;
        if (l) begin
          m_locked = 0; m_ptr = g; m_bcnt = 0;
        end else begin
          if (m_bcnt == MAXB - 1) m_err = 1;
          m_locked = 1; m_owner = g;
          m_bcnt = (m_bcnt + 1 > MAXB) ? MAXB : m_bcnt + 1;
        end
      end else if (out_EN_beat) begin
        m_ov = 0;
      end
    end
    gx = xfer ? g : -1;
    #1;
  endtask

  task automatic set_port(input int i, input bit rdy, input logic [W-1:0] b, input bit l);
    req_RDY_beat[i]      = rdy;
    req_beat[i*W +: W]   = b;
    req_last[i]          = l;
  endtask

  initial begin
    int gx;
    int rem [N];
    logic [31:0] mc0;

    RST = 1'b1;
    req_RDY_beat = '1;
    req_last = '1;
    req_beat = '0;
    out_EN_beat = 1'b0;
    for (int i = 0; i < N; i++) req_beat[i*W +: W] = $urandom;
    model_reset();
    @(posedge CLK);
    #1;

    // Reset held with every port requesting
    for (int c = 0; c < 2; c++) begin
      step(gx);
      chk_eq("rst_no_en", en_seen, 0);
    end
    chk_eq("rst_out_rdy", out_RDY_beat, 0);
    chk_eq("rst_msg_count", msg_count, 0);

    // Fairness: single-beat messages from all ports, sink always takes
    RST = 1'b0;
    out_EN_beat = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) set_port(i, 1, $urandom, 1);
      step(gx);
      chk_eq("fair_port", out_port, k % N);
    end
    req_RDY_beat = '0;
    step(gx);
    chk_eq("fair_msg8", msg_count, 8);

    // Atomicity: port 1 pauses mid-message while port 2 waits
    set_port(1, 1, 32'hA1, 0);
    set_port(2, 1, 32'hB1, 1);
    step(gx);
    chk_eq("atom_a1", out_beat, 32'hA1);
    set_port(1, 0, 32'h0, 0);
    for (int c = 0; c < 2; c++) begin
      step(gx);
      chk_eq("atom_p2_blocked", en_seen[2], 0);
    end
    set_port(1, 1, 32'hA2, 0);
    step(gx);
    chk_eq("atom_p2_blocked", en_seen[2], 0);
    chk_eq("atom_a2", out_beat, 32'hA2);
    set_port(1, 1, 32'hA3, 1);
    step(gx);
    chk_eq("atom_p2_blocked", en_seen[2], 0);
    chk_eq("atom_a3", out_beat, 32'hA3);
    set_port(1, 0, 32'h0, 0);
    step(gx);
    chk_eq("atom_b1", out_beat, 32'hB1);
    chk_eq("atom_b1_port", out_port, 2);

    // Backpressure with 0xDEADBEEF buffered
    set_port(2, 0, 32'h0, 0);
    set_port(0, 1, 32'hDEADBEEF, 1);
    step(gx);
    set_port(0, 0, 32'h0, 0);
    set_port(3, 1, 32'h33, 1);
    out_EN_beat = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(gx);
      chk_eq("bp_no_en", en_seen, 0);
      chk_eq("bp_beat", out_beat, 32'hDEADBEEF);
      chk_eq("bp_rdy", out_RDY_beat, 1);
    end
    out_EN_beat = 1'b1;
    step(gx);
    chk_eq("bp_release_en", en_seen, 4'b1000);
    chk_eq("bp_next_beat", out_beat, 32'h33);

    // Over-length: 6-beat message with maxbeats=4
    req_RDY_beat = '0;
    step(gx);
    mc0 = m_msg;
    for (int k = 1; k <= 6; k++) begin
      set_port(0, 1, 32'h100 + k, k == 6);
      step(gx);
      chk_eq("ovl_err", err_overlength, k >= 4);
    end
    req_RDY_beat = '0;
    step(gx);
    chk_eq("ovl_msg_once", msg_count, mc0 + 1);
    chk_eq("ovl_sticky", err_overlength, 1);

    // Reset in the middle of a port 3 message
    set_port(3, 1, 32'h301, 0);
    step(gx);
    set_port(3, 1, 32'h302, 0);
    step(gx);
    set_port(0, 1, 32'h0A, 1);
    set_port(3, 1, 32'h303, 1);
    RST = 1'b1;
    step(gx);
    chk_eq("mid_rst_no_en", en_seen, 0);
    RST = 1'b0;
    #1;
    chk_eq("mid_rst_out_rdy", out_RDY_beat, 0);
    chk_eq("mid_rst_err_clr", err_overlength, 0);
    step(gx);
    chk_eq("mid_rst_grant_p0", en_seen, 4'b0001);
    chk_eq("mid_rst_port", out_port, 0);

    // Randomized traffic
    req_RDY_beat = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      RST = ($urandom_range(0, 199) == 0);
      out_EN_beat = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) rem[i] = $urandom_range(1, 6);
        set_port(i, $urandom_range(0, 3) != 0, $urandom, rem[i] == 1);
      end
      step(gx);
      if (gx >= 0) rem[gx]--;
    end
    RST = 1'b0;
    req_RDY_beat = '0;
    out_EN_beat = 1'b1;
    for (int c = 0; c < 3; c++) step(gx);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
